// File: rtl/ps2_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Holds the FSM state enum, bit-fall indices, command bytes, parity helper.
package ps2_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        ACK,
        WAIT_IDLE
    } state_e;

    // Index of the device clock fall that triggers each frame action.
    localparam logic [3:0] LAST_DATA_FALL = 4'd8;
    localparam logic [3:0] PARITY_FALL    = 4'd9;
    localparam logic [3:0] STOP_FALL      = 4'd10;
    localparam logic [3:0] ACK_FALL       = 4'd11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_sync_edge.sv
// ps2_sync_edge: 2-FF synchronizer for a raw PS/2 pin plus a registered
// falling-edge pulse. Ports: clock_i, reset_i, pin_i -> level_o, fall_o.
module ps2_sync_edge (
    input  logic clock_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       fall_q;

    // Idle bus level is high, so reset to 1 to avoid a false fall.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            prev_q <= sync_q[1];
            fall_q <= prev_q & ~sync_q[1];
        end
    end

    assign level_o = sync_q[1];
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host->device over open-drain PS/2.
// Ports: clock, reset, tx_data/tx_valid/tx_ready handshake, tx_busy,
// tx_done/tx_error pulses, ps2_clock_in/ps2_data_in raw pins,
// ps2_clock_oe/ps2_data_oe (1 = pull low). Optional watchdog via
// macro PS2_TX_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module ps2_host_tx
    import ps2_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INH_W =
        (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    logic clk_lvl;
    logic clk_fall;
    logic data_lvl;

    ps2_sync_edge u_sync_clk (
        .clock_i (clock),
        .reset_i (reset),
        .pin_i   (ps2_clock_in),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clock_i (clock),
        .reset_i (reset),
        .pin_i   (ps2_data_in),
        .level_o (data_lvl),
        .fall_o  ()
    );

    state_e           state_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic             ack_seen_q;
    logic             clk_oe_q;
    logic             data_oe_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic [3:0]       fall_n;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WD_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q;
    logic            wd_run;
    assign wd_run = (state_q == BITS) || (state_q == ACK) ||
                    (state_q == WAIT_IDLE);
`endif

    // Number of the fall currently being serviced (1-based).
    assign fall_n = bit_cnt_q + 4'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            inh_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            ack_seen_q <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tx_valid && ready_q) begin
                        shift_q    <= tx_data;
                        parity_q   <= odd_parity(tx_data);
                        ack_seen_q <= 1'b0;
                        inh_cnt_q  <= '0;
                        clk_oe_q   <= 1'b1;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt_q == INH_LAST) begin
                        data_oe_q <= 1'b1;
                        state_q   <= REQ;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                    end
                end
                REQ: begin
                    // Data stays low: that is the start bit.
                    clk_oe_q  <= 1'b0;
                    bit_cnt_q <= '0;
                    state_q   <= BITS;
                end
                BITS: begin
                    if (clk_fall) begin
                        bit_cnt_q <= fall_n;
                        unique case (1'b1)
                            (fall_n <= LAST_DATA_FALL): begin
                                data_oe_q <= ~shift_q[0];
                                shift_q   <= {1'b0, shift_q[7:1]};
                            end
                            (fall_n == PARITY_FALL): begin
                                data_oe_q <= ~parity_q;
                            end
                            (fall_n >= STOP_FALL): begin
                                data_oe_q <= 1'b0;
                                state_q   <= ACK;
                            end
                            default: ;
                        endcase
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        bit_cnt_q <= ACK_FALL;
                        if (!data_lvl) begin
                            ack_seen_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_lvl && data_lvl) begin
                        done_q  <= ack_seen_q;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // Every state change inside the watched states coincides
            // with a detected fall, so clearing on fall covers both.
            if (!wd_run || clk_fall) begin
                wd_q <= '0;
            end else if (wd_q == WD_LAST) begin
                wd_q      <= '0;
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                done_q    <= 1'b0;
                error_q   <= 1'b1;
                ready_q   <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= IDLE;
            end else begin
                wd_q <= wd_q + 1'b1;
            end
`endif
        end
    end

    assign tx_ready     = ready_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;
    assign tx_error     = error_q;
    assign ps2_clock_oe = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
// Frame bits are scoreboarded at send time and checked at device sampling.
module tb_ps2_host_tx;
    import ps2_tx_pkg::*;

    localparam int INH = 100;
    localparam int TO  = 1000;
    localparam int H   = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clock_in;
    logic       ps2_data_in;
    logic       ps2_clock_oe;
    logic       ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int npass = 0;
    int ntot  = 0;

    logic sb[$];

    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    int err_cyc = 0;
    int inh_run = 0;
    int inh_meas = 0;
    int data_rise_cyc = 0;
    int req_meas = 0;
    int req_exit_cyc = 0;
    logic prev_coe = 1'b0;
    logic prev_doe = 1'b0;

    // Open-drain bus with pull-ups.
    assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
    assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_error     (tx_error),
        .ps2_clock_in (ps2_clock_in),
        .ps2_data_in  (ps2_data_in),
        .ps2_clock_oe (ps2_clock_oe),
        .ps2_data_oe  (ps2_data_oe)
    );

    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (tx_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (tx_error === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (ps2_clock_oe === 1'b1 && ps2_data_oe === 1'b0)
            inh_run <= inh_run + 1;
        else if (ps2_clock_oe !== 1'b1)
            inh_run <= 0;
        if (ps2_data_oe === 1'b1 && prev_doe !== 1'b1 &&
            ps2_clock_oe === 1'b1) begin
            inh_meas      <= inh_run;
            data_rise_cyc <= cyc;
        end
        if (ps2_clock_oe === 1'b0 && prev_coe === 1'b1 &&
            ps2_data_oe === 1'b1) begin
            req_meas     <= cyc - data_rise_cyc;
            req_exit_cyc <= cyc;
        end
        prev_coe <= ps2_clock_oe;
        prev_doe <= ps2_data_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < 8; i++) sb.push_back(b[i]);
        sb.push_back(~^b);
        sb.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        push_frame(b);
        @(negedge clock);
        tx_valid = 1'b0;
        chk("accept_busy", 32'(tx_busy), 1);
        chk("accept_clk_oe", 32'(ps2_clock_oe), 1);
    endtask

    // Device: waits for request-to-send, clocks 11 falls, samples each
    // bit on the rising clock, optionally ACKs on fall 11.
    task automatic dev_xfer(input bit ack, input int poke_fall,
                            input int abort_fall);
        int   w;
        logic exp_b;
        w = 0;
        while (!(ps2_clock_in === 1'b1 && ps2_data_in === 1'b0) &&
               w < INH + 50) begin
            @(negedge clock);
            w++;
        end
        chk("req_seen", 32'(w < INH + 50), 1);
        repeat (5) @(negedge clock);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (6) @(negedge clock);
            if (k == abort_fall) begin
                reset = 1'b1;
                @(negedge clock);
                chk("abort_clk_oe", 32'(ps2_clock_oe), 0);
                chk("abort_data_oe", 32'(ps2_data_oe), 0);
                reset = 1'b0;
                dev_clk_low = 1'b0;
                dev_data_low = 1'b0;
                sb.delete();
                return;
            end
            if (k == poke_fall) begin
                tx_data  = 8'h00;
                tx_valid = 1'b1;
                @(negedge clock);
                tx_valid = 1'b0;
            end
            repeat (H - 8) @(negedge clock);
            dev_clk_low = 1'b0;
            if (k <= 10) begin
                if (sb.size() > 0) exp_b = sb.pop_front();
                else exp_b = 1'bx;
                chk($sformatf("bit_fall%0d", k), 32'(ps2_data_in),
                    32'(exp_b));
            end
            repeat (H) @(negedge clock);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_evt(input string tag, input int d0, input int e0);
        int w;
        w = 0;
        while (done_cnt == d0 && err_cnt == e0 && w < 200) begin
            @(negedge clock);
            w++;
        end
        chk(tag, 32'(w < 200), 1);
        repeat (5) @(negedge clock);
    endtask

    initial begin
        int d0;
        int e0;
        int dcyc;
        int w;

        // Reset held two cycles.
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_clk_oe", 32'(ps2_clock_oe), 0);
        chk("rst_data_oe", 32'(ps2_data_oe), 0);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_error", 32'(tx_error), 0);
        repeat (3) @(negedge clock);

        // 0xED with ACK.
        d0 = done_cnt;
        e0 = err_cnt;
        send(CMD_SET_LEDS);
        dev_xfer(1'b1, 0, 0);
        wait_evt("ed_evt", d0, e0);
        chk("ed_inhibit_len", inh_meas, INH);
        chk("ed_req_len", req_meas, 1);
        chk("ed_done_cnt", done_cnt - d0, 1);
        chk("ed_err_cnt", err_cnt - e0, 0);
        chk("ed_clk_oe", 32'(ps2_clock_oe), 0);
        chk("ed_data_oe", 32'(ps2_data_oe), 0);
        chk("ed_ready", 32'(tx_ready), 1);
        chk("ed_sb_left", sb.size(), 0);

        // 0xF4, no ACK, tx_valid poked mid-frame.
        d0 = done_cnt;
        e0 = err_cnt;
        send(CMD_ENABLE);
        dev_xfer(1'b0, 3, 0);
        wait_evt("f4_evt", d0, e0);
        chk("f4_err_cnt", err_cnt - e0, 1);
        chk("f4_done_cnt", done_cnt - d0, 0);
        chk("f4_clk_oe", 32'(ps2_clock_oe), 0);
        chk("f4_data_oe", 32'(ps2_data_oe), 0);
        chk("f4_ready", 32'(tx_ready), 1);
        repeat (20) @(negedge clock);
        chk("poke_ignored_busy", 32'(tx_busy), 0);
        chk("f4_sb_left", sb.size(), 0);

        // Reset at fall 5.
        send(CMD_SET_LEDS);
        dev_xfer(1'b1, 0, 5);
        repeat (2) @(negedge clock);
        d0 = done_cnt;
        e0 = err_cnt;
        repeat (50) @(negedge clock);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_err", err_cnt - e0, 0);
        chk("abort_ready", 32'(tx_ready), 1);
        chk("abort_busy", 32'(tx_busy), 0);

        // tx_valid held across two sends.
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = CMD_SET_LEDS;
        tx_valid = 1'b1;
        push_frame(CMD_SET_LEDS);
        @(negedge clock);
        chk("held_first_busy", 32'(tx_busy), 1);
        dev_xfer(1'b1, 0, 0);
        w = 0;
        while (tx_done !== 1'b1 && w < 200) begin
            @(negedge clock);
            w++;
        end
        chk("held_first_done", 32'(tx_done), 1);
        chk("held_ready_at_done", 32'(tx_ready), 1);
        tx_data = CMD_ENABLE;
        push_frame(CMD_ENABLE);
        @(negedge clock);
        dcyc = done_cyc;
        tx_valid = 1'b0;
        chk("held_second_busy", 32'(tx_busy), 1);
        dev_xfer(1'b1, 0, 0);
        wait_evt("held_second_evt", done_cnt, err_cnt);
        chk("held_gap_ge", 32'((data_rise_cyc - dcyc) >= INH + 1), 1);
        chk("held_done_cnt", done_cnt - d0, 2);
        chk("held_err_cnt", err_cnt - e0, 0);
        chk("held_sb_left", sb.size(), 0);

`ifdef PS2_TX_TIMEOUT_EN
        // Device never clocks: watchdog fires TO cycles after REQ exit.
        e0 = err_cnt;
        tx_data  = CMD_ENABLE;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        w = 0;
        while (err_cnt == e0 && w < INH + TO + 100) begin
            @(negedge clock);
            w++;
        end
        chk("to_fired", 32'(w < INH + TO + 100), 1);
        repeat (2) @(negedge clock);
        chk("to_latency", err_cyc - req_exit_cyc, TO);
        chk("to_clk_oe", 32'(ps2_clock_oe), 0);
        chk("to_data_oe", 32'(ps2_data_oe), 0);
        chk("to_ready", 32'(tx_ready), 1);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
